// File: rtl/axil_counter_bank.sv
// AXI4-Lite bank of saturating event counters with version, clear and saturation registers.
// Optional AXIL_COUNTER_BANK_SNAPSHOT_EN adds shadow registers captured by CTRL bit 31.
module axil_counter_bank #(
    parameter int          ADDR_W  = 16,
    parameter int          NUM_CNT = 4,
    parameter int          CNT_W   = 32,
    parameter logic [31:0] VERSION = 32'h60DC0DE1
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_arst,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [ADDR_W-1:0]  s_axi_awaddr,
    input  logic [2:0]         s_axi_awprot,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    input  logic [31:0]        s_axi_wdata,
    input  logic [3:0]         s_axi_wstrb,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    output logic [1:0]         s_axi_bresp,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    input  logic [ADDR_W-1:0]  s_axi_araddr,
    input  logic [2:0]         s_axi_arprot,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready,
    output logic [31:0]        s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    input  logic [NUM_CNT-1:0] cnt_en
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   cnt_q [NUM_CNT];
    logic [CNT_W-1:0]   cnt_d [NUM_CNT];
    logic [CNT_W-1:0]   rd_src [NUM_CNT];
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic               rvalid_q, rvalid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               wr_hs, rd_hs, ctrl_hit;
    logic [NUM_CNT-1:0] clr_mask, sat_vec;
    logic               unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wdata, s_axi_wstrb};

    assign s_axi_awready = ~s_axi_arst & s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
    assign s_axi_wready  = s_axi_awready;
    assign s_axi_arready = ~s_axi_arst & s_axi_arvalid & ~rvalid_q;
    assign wr_hs         = s_axi_awready;
    assign rd_hs         = s_axi_arready;
    assign ctrl_hit      = (s_axi_awaddr == ADDR_W'(4));

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;

    // Clear has priority over a same-cycle event; saturation stops the count.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            clr_mask[i] = wr_hs & ctrl_hit & s_axi_wdata[i] & s_axi_wstrb[i/8];
            sat_vec[i]  = (cnt_q[i] == CNT_MAX);
            cnt_d[i]    = cnt_q[i];
            if (clr_mask[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_en[i] && !sat_vec[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

`ifdef AXIL_COUNTER_BANK_SNAPSHOT_EN
    logic [CNT_W-1:0] shad_q [NUM_CNT];
    logic [CNT_W-1:0] shad_d [NUM_CNT];
    logic             snap;

    assign snap = wr_hs & ctrl_hit & s_axi_wdata[31];

    // Shadows take the pre-clear value of the same write.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            shad_d[i] = snap ? cnt_q[i] : shad_q[i];
            rd_src[i] = shad_q[i];
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        for (int i = 0; i < NUM_CNT; i++) begin
            if (s_axi_arst) begin
                shad_q[i] <= '0;
            end else begin
                shad_q[i] <= shad_d[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            rd_src[i] = cnt_q[i];
        end
    end
`endif

    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = ctrl_hit ? 2'b00 : 2'b10;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
        if (rd_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = 2'b10;
            if (s_axi_araddr == ADDR_W'(0)) begin
                rdata_d = VERSION;
                rresp_d = 2'b00;
            end else if (s_axi_araddr == ADDR_W'(4)) begin
                rresp_d = 2'b00;
            end else if (s_axi_araddr == ADDR_W'(8)) begin
                rdata_d = 32'(sat_vec);
                rresp_d = 2'b00;
            end else begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (s_axi_araddr == ADDR_W'(16 + 4*i)) begin
                        rdata_d = 32'(rd_src[i]);
                        rresp_d = 2'b00;
                    end
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_arst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        for (int i = 0; i < NUM_CNT; i++) begin
            if (s_axi_arst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_axil_counter_bank.sv
// Bench for axil_counter_bank: cycle model of the register map plus directed literals.
// Build with AXIL_COUNTER_BANK_SNAPSHOT_EN defined to cover the shadow registers.
module tb_axil_counter_bank;

    localparam int ADDR_W  = 16;
    localparam int NUM_CNT = 4;
    localparam int CNT_W   = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam logic [31:0] VER = 32'h60DC0DE1;
`ifdef AXIL_COUNTER_BANK_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic [3:0] wstrb = '0;
    logic [1:0] bresp, rresp;
    logic [NUM_CNT-1:0] cnt_en = '0;

    always #5 clk = ~clk;

    axil_counter_bank #(
        .ADDR_W(ADDR_W), .NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .VERSION(VER)
    ) dut (
        .s_axi_aclk(clk), .s_axi_arst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .cnt_en(cnt_en)
    );

    int pass_cnt = 0;
    int total = 0;
    bit started = 0;

    function void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endfunction

    function void tmo(string nm);
        total++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endfunction

    // Reference model: counters as plain integers, channels as flags.
    int m_cnt [NUM_CNT];
    int m_shad [NUM_CNT];
    bit m_bvalid, m_rvalid;
    logic [1:0] m_bresp, m_rresp;
    logic [31:0] m_rdata;
    bit wr_acc, rd_acc, ctrl_w;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                m_cnt[i] = 0;
                m_shad[i] = 0;
            end
            m_bvalid = 0;
            m_rvalid = 0;
        end else begin
            wr_acc = awvalid && wvalid && !m_bvalid;
            rd_acc = arvalid && !m_rvalid;
            ctrl_w = wr_acc && (awaddr == 4);
            if (m_bvalid && bready) m_bvalid = 0;
            if (m_rvalid && rready) m_rvalid = 0;
            if (rd_acc) begin
                m_rvalid = 1;
                m_rresp = 2'b00;
                m_rdata = 0;
                if (araddr == 0) begin
                    m_rdata = VER;
                end else if (araddr == 4) begin
                    m_rdata = 0;
                end else if (araddr == 8) begin
                    for (int i = 0; i < NUM_CNT; i++)
                        if (m_cnt[i] == CMAX) m_rdata[i] = 1'b1;
                end else if (araddr >= 16 && araddr < 16 + 4*NUM_CNT
                             && araddr % 4 == 0) begin
                    if (SNAP) m_rdata = m_shad[(araddr - 16) / 4];
                    else m_rdata = m_cnt[(araddr - 16) / 4];
                end else begin
                    m_rresp = 2'b10;
                end
            end
            if (ctrl_w && SNAP && wdata[31])
                for (int i = 0; i < NUM_CNT; i++) m_shad[i] = m_cnt[i];
            for (int i = 0; i < NUM_CNT; i++) begin
                if (ctrl_w && wdata[i] && wstrb[i/8]) m_cnt[i] = 0;
                else if (cnt_en[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
            end
            if (wr_acc) begin
                m_bvalid = 1;
                m_bresp = ctrl_w ? 2'b00 : 2'b10;
            end
        end
    end

    initial begin
        wait (started);
        forever begin
            @(negedge clk);
            #2;
            chk("awready", awready, !rst && awvalid && wvalid && !m_bvalid);
            chk("wready", wready, !rst && awvalid && wvalid && !m_bvalid);
            chk("arready", arready, !rst && arvalid && !m_rvalid);
            chk("bvalid", bvalid, m_bvalid);
            chk("rvalid", rvalid, m_rvalid);
            if (m_bvalid) chk("bresp", bresp, m_bresp);
            if (m_rvalid) begin
                chk("rdata", rdata, m_rdata);
                chk("rresp", rresp, m_rresp);
            end
        end
    end

    task automatic wr(input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [1:0] resp);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1;
        #1;
        while (!awready && n < 50) begin @(negedge clk); #1; n++; end
        if (!awready) tmo("wr_accept");
        @(posedge clk);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) tmo("wr_bvalid");
        resp = bresp;
        bready = 1;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic rd(input logic [15:0] a, input int hold,
                      output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        araddr = a; arvalid = 1;
        #1;
        while (!arready && n < 50) begin @(negedge clk); #1; n++; end
        if (!arready) tmo("rd_accept");
        @(posedge clk);
        @(negedge clk);
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        if (!rvalid) tmo("rd_rvalid");
        repeat (hold) begin
            @(negedge clk);
            chk("rvalid_hold", rvalid, 1);
        end
        d = rdata; r = rresp;
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    logic [31:0] d, d2;
    logic [1:0] r, br;

    initial begin
        @(negedge clk);
        started = 1;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        rst = 0;

        rd(16'h00, 0, d, r);
        chk("version", d, VER);
        chk("version_resp", r, 0);
        rd(16'h10, 0, d, r);
        chk("cnt0_init", d, 0);

        cnt_en = 4'b0110;
        repeat (30) @(negedge clk);
        cnt_en = 4'b0010;
        repeat (70) @(negedge clk);
        cnt_en = 4'b0000;
        rd(16'h14, 0, d, r);
        chk("cnt1_100", d, 100);
        wr(16'h04, 32'h2, 4'hF, br);
        chk("ctrl_bresp", br, 0);
        rd(16'h14, 0, d, r);
        chk("cnt1_clr", d, 0);
        rd(16'h18, 0, d, r);
        chk("cnt2_kept", d, 30);

        cnt_en = 4'b0001;
        repeat (300) @(negedge clk);
        cnt_en = 4'b0000;
        rd(16'h10, 0, d, r);
        chk("cnt0_sat", d, 32'h0000_00FF);
        rd(16'h08, 0, d, r);
        chk("sat_reg", d, 32'h1);

        wr(16'h10, 32'hFFFF_FFFF, 4'hF, br);
        chk("ro_bresp", br, 2'b10);
        rd(16'h18, 0, d, r);
        chk("cnt2_ro", d, 30);
        rd(16'h10, 0, d, r);
        chk("cnt0_ro", d, 32'hFF);
        rd(16'h40, 5, d, r);
        chk("unmap_rresp", r, 2'b10);
        chk("unmap_rdata", d, 0);

        fork
            wr(16'h04, 32'h4, 4'hF, br);
            rd(16'h18, 0, d2, r);
        join
        chk("rd_clr_same", d2, 30);
        rd(16'h18, 0, d, r);
        chk("cnt2_after", d, 0);

        cnt_en = 4'b1000;
        wr(16'h04, 32'h8, 4'h1, br);
        repeat (3) @(negedge clk);
        wr(16'h04, 32'h8, 4'h2, br);
        cnt_en = 4'b0000;
        rd(16'h1C, 0, d, r);

        wr(16'h04, 32'hF, 4'hF, br);
        cnt_en = 4'b0001;
        repeat (50) @(negedge clk);
        cnt_en = 4'b0000;
        wr(16'h04, 32'h8000_0001, 4'hF, br);
        cnt_en = 4'b0001;
        repeat (20) @(negedge clk);
        cnt_en = 4'b0000;
        chk("model_live0", m_cnt[0], 20);
        rd(16'h10, 0, d, r);
        chk("snap_read", d, SNAP ? 50 : 20);

        cnt_en = 4'b1111;
        repeat (10) @(negedge clk);
        cnt_en = 4'b0000;
        awaddr = 16'h04; wdata = 0; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("bvalid_pend", bvalid, 1);
        rst = 1;
        @(negedge clk);
        chk("bvalid_rst", bvalid, 0);
        rst = 0;
        for (int i = 0; i < NUM_CNT; i++) begin
            rd(16'(16 + 4*i), 0, d, r);
            chk("cnt_rst", d, 0);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/axil_counter_bank.md
AXIL_COUNTER_BANK -- requirements
Module: axil_counter_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, AXI4-Lite address width.
REQ-002 SHALL have parameter NUM_CNT, default 4, number of event counters (legal 1..16).
REQ-003 SHALL have parameter CNT_W, default 32, counter width (legal 8..32).
REQ-004 SHALL have parameter VERSION, default 32'h60DC0DE1, value of the version register.
REQ-005 SHALL use one clock and a synchronous, active-high reset: s_axi_aclk and s_axi_arst.
REQ-006 Ports: s_axi_aclk  in  1  clock; s_axi_arst  in  1  sync active-high reset.
REQ-007 Ports: s_axi_awvalid in 1, s_axi_awready out 1, s_axi_awaddr in ADDR_W, s_axi_awprot in 3 (ignored).
REQ-008 Ports: s_axi_wvalid in 1, s_axi_wready out 1, s_axi_wdata in 32, s_axi_wstrb in 4.
REQ-009 Ports: s_axi_bvalid out 1, s_axi_bready in 1, s_axi_bresp out 2.
REQ-010 Ports: s_axi_arvalid in 1, s_axi_arready out 1, s_axi_araddr in ADDR_W, s_axi_arprot in 3 (ignored).
REQ-011 Ports: s_axi_rvalid out 1, s_axi_rready in 1, s_axi_rdata out 32, s_axi_rresp out 2.
REQ-012 Ports: cnt_en  in  NUM_CNT  per-counter increment enable, one event per cycle when high.

Function
REQ-013 Register map, offsets use awaddr/araddr[ADDR_W-1:0]: 0x00 VERSION RO; 0x04 CTRL WO; 0x08 SAT RO; 0x10+4*i CNT[i] RO, i<NUM_CNT.
REQ-014 Write: awready and wready SHALL assert together, one cycle, only when awvalid, wvalid high and bvalid low.
REQ-015 bvalid SHALL assert the cycle after the write handshake and hold until bready; no new write accepted while bvalid high.
REQ-016 Write to CTRL SHALL give bresp 2'b00; write to any other offset SHALL give bresp 2'b10 (SLVERR) with no state change.
REQ-017 Read: arready SHALL be high when arvalid high and rvalid low; rvalid SHALL assert the next cycle and hold, rdata/rresp stable, until rready.
REQ-018 Read of a mapped offset SHALL give rresp 2'b00; unmapped offset SHALL give rresp 2'b10 and rdata 0.
REQ-019 CNT[i] SHALL increment by 1 per cycle with cnt_en[i] high and saturate at all-ones (no wrap).
REQ-020 SAT bit i SHALL read 1 while CNT[i] is all-ones; bits >= NUM_CNT read 0.
REQ-021 CTRL write with wdata[i]=1 and wstrb covering bit i SHALL clear CNT[i] to 0 the cycle after the write handshake.
REQ-022 Clear and cnt_en[i] in the same cycle: clear SHALL win (counter becomes 0, that event is lost).
REQ-023 Counter reads SHALL zero-extend CNT_W to 32 bits; value returned is the counter at the arready handshake cycle.
REQ-024 Simultaneous read and write handshakes SHALL both be accepted; a read of CNT[i] coinciding with its clear returns the pre-clear value.

Reset
REQ-025 On s_axi_arst high at a rising edge: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; all CNT[i] = 0.
REQ-026 Reset mid-transaction SHALL abort it without response; first handshake accepted the cycle after s_axi_arst falls.

Configuration
REQ-027 Macro AXIL_COUNTER_BANK_SNAPSHOT_EN: when defined, a CTRL write with wdata[31]=1 SHALL copy all counters into shadow registers and CNT[i] reads SHALL return the shadow; snapshot precedes any same-write clear (captures pre-clear values); shadows reset to 0.
REQ-028 When AXIL_COUNTER_BANK_SNAPSHOT_EN is undefined, wdata[31] SHALL be ignored and CNT[i] reads SHALL return live counter values.

Verification
REQ-029 After reset, read 0x00 -> rdata 32'h60DC0DE1, rresp 00; read 0x10 -> 0.
REQ-030 cnt_en[1] high 100 cycles, read 0x14 -> 100; CTRL write 32'h2, wstrb 4'hF -> read 0x14 -> 0, other counters unchanged.
REQ-031 CNT_W=8, cnt_en[0] high 300 cycles -> read 0x10 -> 32'h000000FF; read 0x08 -> bit0 set.
REQ-032 Write 0x10 -> bresp 10, counter unchanged; read 0x40 with NUM_CNT=4 -> rresp 10, rdata 0; rready held low 5 cycles -> rvalid/rdata stable.
REQ-033 SNAPSHOT_EN: count 50 on cnt_en[0], CTRL write 32'h80000001, count 20 more -> read 0x10 -> 50, live counter 20.
REQ-034 Assert s_axi_arst with bvalid pending -> bvalid 0 next cycle, all counters 0.
